// File: rtl/exec_ctrl.sv
// Single-issue execute controller for a 4x8 register file.
// Accepts one instruction, reads its source register, runs the 8-bit ALU
// and writes the result back. Fixed four-state path: IDLE, READ, EXEC, WRITE.
module exec_ctrl (
  input  logic       ck,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] op,
  input  logic [1:0] rd,
  input  logic [1:0] rs,
  input  logic [7:0] imm,
  input  logic [7:0] dout,
  output logic [1:0] outaddr,
  output logic       we,
  output logic [1:0] inaddr,
  output logic [7:0] din,
  output logic       done,
  output logic       zero,
  output logic       carry
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC,
    WRITE
  } state_t;

  typedef enum logic [2:0] {
    OP_LDI = 3'b000,
    OP_MOV = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_NOT = 3'b111
  } op_t;

  state_t     state_q;
  op_t        op_q;
  logic [1:0] rd_q;
  logic [7:0] imm_q;
  logic [7:0] a_q;

  logic [7:0] res_d;
  logic       carry_d;
  logic [8:0] sum;

  // ALU: result and carry/borrow from the latched operand and immediate
  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    sum     = {1'b0, a_q} + {1'b0, imm_q};
    unique case (op_q)
      OP_LDI: res_d = imm_q;
      OP_MOV: res_d = a_q;
      OP_ADD: begin
        res_d   = sum[7:0];
        carry_d = sum[8];
      end
      OP_SUB: begin
        res_d   = a_q - imm_q;
        carry_d = (a_q < imm_q);
      end
      OP_AND: res_d = a_q & imm_q;
      OP_OR:  res_d = a_q | imm_q;
      OP_XOR: res_d = a_q ^ imm_q;
      OP_NOT: res_d = ~a_q;
      default: res_d = '0;
    endcase
  end

  // Control FSM with registered outputs; the source address is captured
  // straight into outaddr on accept, so it is valid for the whole READ cycle.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_LDI;
      rd_q     <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      in_ready <= 1'b1;
      outaddr  <= '0;
      we       <= 1'b0;
      inaddr   <= '0;
      din      <= '0;
      done     <= 1'b0;
      zero     <= 1'b0;
      carry    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q     <= op_t'(op);
            rd_q     <= rd;
            imm_q    <= imm;
            outaddr  <= rs;
            in_ready <= 1'b0;
            state_q  <= READ;
          end
        end
        READ: begin
          a_q     <= dout;
          state_q <= EXEC;
        end
        EXEC: begin
          din     <= res_d;
          inaddr  <= rd_q;
          zero    <= (res_d == '0);
          carry   <= carry_d;
          we      <= 1'b1;
          done    <= 1'b1;
          state_q <= WRITE;
        end
        WRITE: begin
          we       <= 1'b0;
          done     <= 1'b0;
          in_ready <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl: bench-side 4x8 regfile, transaction-level reference
// model, per-cycle comparison plus directed literal checks.
module tb_exec_ctrl;

  logic       ck = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] op = '0;
  logic [1:0] rd = '0;
  logic [1:0] rs = '0;
  logic [7:0] imm = '0;
  logic [7:0] dout;
  logic [7:0] din;
  logic [1:0] outaddr;
  logic [1:0] inaddr;
  logic       in_ready, we, done, zero, carry;

  logic [7:0] rf [4] = '{default: 8'h00};
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  exec_ctrl dut (
    .ck       (ck),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .rd       (rd),
    .rs       (rs),
    .imm      (imm),
    .dout     (dout),
    .outaddr  (outaddr),
    .we       (we),
    .inaddr   (inaddr),
    .din      (din),
    .done     (done),
    .zero     (zero),
    .carry    (carry)
  );

  always #5 ck = ~ck;

  // Register file seen by the DUT
  always @(posedge ck) begin
    cyc <= cyc + 1;
    if (we) rf[inaddr] <= din;
  end
  assign dout = rf[outaddr];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ALU reference from the opcode table, in plain integer arithmetic
  function automatic logic [8:0] ref_alu(input int o, input int a, input int b);
    int r;
    int c;
    c = 0;
    case (o)
      0: r = b;
      1: r = a;
      2: begin r = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
      3: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      default: r = 255 - a;
    endcase
    return 9'(c * 256 + r);
  endfunction

  // Reference model: age = cycles since accept (-1 when idle)
  int         age = -1;
  logic [7:0] m_rf [4] = '{default: 8'h00};
  logic [8:0] m_t;
  logic [7:0] m_res = '0;
  logic       m_c = 1'b0;
  logic [1:0] m_rd = '0;
  logic [1:0] e_out = '0;
  logic [1:0] e_ina = '0;
  logic [7:0] e_din = '0;
  logic       e_z = 1'b0;
  logic       e_c = 1'b0;

  always @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      age = -1; e_out = '0; e_ina = '0; e_din = '0; e_z = 1'b0; e_c = 1'b0;
    end else if (age < 0) begin
      if (in_valid) begin
        m_t   = ref_alu(int'(op), int'(m_rf[rs]), int'(imm));
        m_res = m_t[7:0];
        m_c   = m_t[8];
        m_rd  = rd;
        e_out = rs;
        age   = 0;
      end
    end else begin
      age++;
      if (age == 2) begin
        e_din = m_res; e_ina = m_rd; e_z = (m_res == 8'h00); e_c = m_c;
      end
      if (age == 3) begin
        m_rf[m_rd] = m_res;
        age = -1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge ck) begin
    chk("in_ready", int'(in_ready), (age < 0) ? 1 : 0);
    chk("we", int'(we), (age == 2) ? 1 : 0);
    chk("done", int'(done), (age == 2) ? 1 : 0);
    chk("outaddr", int'(outaddr), int'(e_out));
    chk("inaddr", int'(inaddr), int'(e_ina));
    chk("din", int'(din), int'(e_din));
    chk("zero", int'(zero), int'(e_z));
    chk("carry", int'(carry), int'(e_c));
    for (int i = 0; i < 4; i++) chk("regfile", int'(rf[i]), int'(m_rf[i]));
  end

  // Present an instruction once in_ready is seen; returns accept edge number
  task automatic issue(input logic [2:0] o, input logic [1:0] d, input logic [1:0] s,
                       input logic [7:0] im, output int acc, output int waits);
    int n;
    n = 0;
    while (!in_ready && n < 10) begin
      @(negedge ck);
      n++;
    end
    chk("in_ready_seen", int'(in_ready), 1);
    waits = n;
    op = o; rd = d; rs = s; imm = im; in_valid = 1'b1;
    acc = cyc + 1;
    @(negedge ck);
    in_valid = 1'b0;
  endtask

  // Wait for done; returns the write edge number, ends one cycle later
  task automatic wait_done(output int wc);
    int n;
    n = 0;
    while (!done && n < 10) begin
      @(negedge ck);
      n++;
    end
    chk("done_seen", int'(done), 1);
    wc = cyc + 1;
    @(negedge ck);
  endtask

  int acc, wt, wc, cnt;

  initial begin
    repeat (3) @(negedge ck);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_we", int'(we), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_din", int'(din), 0);
    rst_n = 1'b1;

    // LDI then MOV
    issue(3'd0, 2'd0, 2'd0, 8'h05, acc, wt);
    chk("first_accept_wait", wt, 0);
    wait_done(wc);
    chk("ldi_r0", int'(rf[0]), 8'h05);
    issue(3'd1, 2'd1, 2'd0, 8'hAA, acc, wt);
    wait_done(wc);
    chk("mov_r1", int'(rf[1]), 8'h05);
    chk("mov_zero", int'(zero), 0);
    chk("mov_carry", int'(carry), 0);

    // ADD with carry out, latency check
    issue(3'd0, 2'd2, 2'd0, 8'hF0, acc, wt);
    wait_done(wc);
    issue(3'd2, 2'd3, 2'd2, 8'h20, acc, wt);
    wait_done(wc);
    chk("add_latency", wc - acc, 3);
    chk("add_r3", int'(rf[3]), 8'h10);
    chk("add_carry", int'(carry), 1);
    chk("add_zero", int'(zero), 0);

    // SUB to zero, then borrow
    issue(3'd0, 2'd1, 2'd0, 8'h05, acc, wt);
    wait_done(wc);
    issue(3'd3, 2'd1, 2'd1, 8'h05, acc, wt);
    wait_done(wc);
    chk("sub_r1", int'(rf[1]), 8'h00);
    chk("sub_zero", int'(zero), 1);
    chk("sub_carry", int'(carry), 0);
    issue(3'd3, 2'd1, 2'd1, 8'h06, acc, wt);
    wait_done(wc);
    chk("sub_borrow_r1", int'(rf[1]), 8'hFA);
    chk("sub_borrow_carry", int'(carry), 1);

    // Continuous in_valid: one accept per four cycles
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) cnt++;
      op = 3'($urandom); rd = 2'($urandom); rs = 2'($urandom); imm = 8'($urandom);
      in_valid = 1'b1;
      @(negedge ck);
    end
    in_valid = 1'b0;
    chk("throughput_accepts", cnt, 10);
    repeat (4) @(negedge ck);

    // Reset during EXEC of an ADD aimed at R0
    issue(3'd0, 2'd0, 2'd0, 8'h05, acc, wt);
    wait_done(wc);
    issue(3'd2, 2'd0, 2'd3, 8'h01, acc, wt);
    @(negedge ck);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we", int'(we), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_outaddr", int'(outaddr), 0);
    chk("abort_carry", int'(carry), 0);
    repeat (2) @(negedge ck);
    rst_n = 1'b1;
    issue(3'd0, 2'd2, 2'd0, 8'h7F, acc, wt);
    chk("post_reset_accept_wait", wt, 0);
    wait_done(wc);
    chk("abort_r0_kept", int'(rf[0]), 8'h05);
    chk("post_reset_r2", int'(rf[2]), 8'h7F);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      op = 3'($urandom); rd = 2'($urandom); rs = 2'($urandom); imm = 8'($urandom);
      @(negedge ck);
    end
    in_valid = 1'b0;
    repeat (6) @(negedge ck);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
